alt_mem_ddrx_itf_cmd_buffer: RTL and testbench



---
 rtl/alt_mem_ddrx_itf_cmd_buffer_if.sv | 49 ++++
 rtl/alt_mem_ddrx_itf_cmd_buffer.sv | 154 +++++++++++++++
 tb/tb_alt_mem_ddrx_itf_cmd_buffer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alt_mem_ddrx_itf_cmd_buffer_if.sv
// Bundle of the upstream command/write-data ports and the downstream buffered ports.
// The slave side is the buffer; the master side is whatever drives it.
interface alt_mem_ddrx_itf_cmd_buffer_if #(
    parameter int AVL_ADDR_WIDTH = 25,
    parameter int AVL_SIZE_WIDTH = 3,
    parameter int AVL_DATA_WIDTH = 32
);
    logic                          itf_cmd_valid;
    logic                          itf_cmd_ready;
    logic                          itf_cmd;
    logic [AVL_ADDR_WIDTH-1:0]     itf_cmd_address;
    logic [AVL_SIZE_WIDTH-1:0]     itf_cmd_burstlen;
    logic                          itf_wr_data_valid;
    logic                          itf_wr_data_ready;
    logic [AVL_DATA_WIDTH-1:0]     itf_wr_data;
    logic [AVL_DATA_WIDTH/8-1:0]   itf_wr_data_byte_en;

    logic                          buf_cmd_valid;
    logic                          buf_cmd_ready;
    logic                          buf_cmd_write;
    logic [AVL_ADDR_WIDTH-1:0]     buf_cmd_address;
    logic [AVL_SIZE_WIDTH-1:0]     buf_cmd_burstlen;
    logic                          buf_wr_data_valid;
    logic                          buf_wr_data_ready;
    logic [AVL_DATA_WIDTH-1:0]     buf_wr_data;
    logic [AVL_DATA_WIDTH/8-1:0]   buf_wr_data_byte_en;
    logic                          buf_wr_data_begin;
    logic                          buf_wr_data_last;

    modport master (
        output itf_cmd_valid, itf_cmd, itf_cmd_address, itf_cmd_burstlen,
        output itf_wr_data_valid, itf_wr_data, itf_wr_data_byte_en,
        output buf_cmd_ready, buf_wr_data_ready,
        input  itf_cmd_ready, itf_wr_data_ready,
        input  buf_cmd_valid, buf_cmd_write, buf_cmd_address, buf_cmd_burstlen,
        input  buf_wr_data_valid, buf_wr_data, buf_wr_data_byte_en,
        input  buf_wr_data_begin, buf_wr_data_last
    );

    modport slave (
        input  itf_cmd_valid, itf_cmd, itf_cmd_address, itf_cmd_burstlen,
        input  itf_wr_data_valid, itf_wr_data, itf_wr_data_byte_en,
        input  buf_cmd_ready, buf_wr_data_ready,
        output itf_cmd_ready, itf_wr_data_ready,
        output buf_cmd_valid, buf_cmd_write, buf_cmd_address, buf_cmd_burstlen,
        output buf_wr_data_valid, buf_wr_data, buf_wr_data_byte_en,
        output buf_wr_data_begin, buf_wr_data_last
    );
endinterface

// File: rtl/alt_mem_ddrx_itf_cmd_buffer.sv
// Command / write-data buffer: independent command and data FIFOs plus a write-length
// queue that frames the data stream into bursts with begin/last markers.

module alt_mem_ddrx_itf_cmd_buffer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW:0]      rd_ptr_reg, rd_ptr_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (do_push) wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
        if (do_pop)  rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end

    // Head entry falls through; a pushed entry is only visible the cycle after.
    assign rdata = mem[rd_ptr_reg[AW-1:0]];
endmodule

module alt_mem_ddrx_itf_cmd_buffer #(
    parameter int AVL_ADDR_WIDTH  = 25,
    parameter int AVL_SIZE_WIDTH  = 3,
    parameter int AVL_DATA_WIDTH  = 32,
    parameter int CMD_FIFO_DEPTH  = 4,
    parameter int DATA_FIFO_DEPTH = 8
) (
    input  logic                         ctl_clk,
    input  logic                         ctl_reset,
    alt_mem_ddrx_itf_cmd_buffer_if.slave bus
);
    localparam int BE_WIDTH = AVL_DATA_WIDTH / 8;
    localparam int CMD_W    = 1 + AVL_ADDR_WIDTH + AVL_SIZE_WIDTH;
    localparam int DATA_W   = AVL_DATA_WIDTH + BE_WIDTH;

    logic                      cmd_full, cmd_empty, cmd_push, cmd_pop;
    logic [CMD_W-1:0]          cmd_head;
    logic                      data_full, data_empty, data_push, data_pop;
    logic [DATA_W-1:0]         data_head;
    logic                      wlen_full, wlen_empty, wlen_push, wlen_pop;
    logic [AVL_SIZE_WIDTH-1:0] wlen_head;
    logic [AVL_SIZE_WIDTH-1:0] last_idx;
    logic [AVL_SIZE_WIDTH-1:0] beat_cnt_reg, beat_cnt_next;
    logic                      wr_valid, beat_last;

    // Ready depends only on FIFO pointer state, so a pop never frees a slot same-cycle.
    assign bus.itf_cmd_ready     = !cmd_full && !wlen_full;
    assign bus.itf_wr_data_ready = !data_full;

    assign cmd_push  = bus.itf_cmd_valid && bus.itf_cmd_ready;
    assign wlen_push = cmd_push && bus.itf_cmd;
    assign data_push = bus.itf_wr_data_valid && bus.itf_wr_data_ready;

    assign cmd_pop   = bus.buf_cmd_valid && bus.buf_cmd_ready;
    assign data_pop  = wr_valid && bus.buf_wr_data_ready;
    assign wlen_pop  = data_pop && beat_last;

    alt_mem_ddrx_itf_cmd_buffer_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_FIFO_DEPTH)) cmd_fifo (
        .clk   (ctl_clk),
        .rst   (ctl_reset),
        .push  (cmd_push),
        .pop   (cmd_pop),
        .wdata ({bus.itf_cmd, bus.itf_cmd_address, bus.itf_cmd_burstlen}),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    alt_mem_ddrx_itf_cmd_buffer_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_FIFO_DEPTH)) data_fifo (
        .clk   (ctl_clk),
        .rst   (ctl_reset),
        .push  (data_push),
        .pop   (data_pop),
        .wdata ({bus.itf_wr_data, bus.itf_wr_data_byte_en}),
        .rdata (data_head),
        .full  (data_full),
        .empty (data_empty)
    );

    alt_mem_ddrx_itf_cmd_buffer_fifo #(.WIDTH(AVL_SIZE_WIDTH), .DEPTH(CMD_FIFO_DEPTH)) wlen_fifo (
        .clk   (ctl_clk),
        .rst   (ctl_reset),
        .push  (wlen_push),
        .pop   (wlen_pop),
        .wdata (bus.itf_cmd_burstlen),
        .rdata (wlen_head),
        .full  (wlen_full),
        .empty (wlen_empty)
    );

    assign bus.buf_cmd_valid = !cmd_empty;
    assign {bus.buf_cmd_write, bus.buf_cmd_address, bus.buf_cmd_burstlen} = cmd_head;

    // Beats are only released once a write length is known to frame them.
    assign wr_valid                = !data_empty && !wlen_empty;
    assign bus.buf_wr_data_valid   = wr_valid;
    assign {bus.buf_wr_data, bus.buf_wr_data_byte_en} = data_head;

    // A zero burst length is treated as a single beat.
    assign last_idx  = (wlen_head == '0) ? '0 : wlen_head - AVL_SIZE_WIDTH'(1);
    assign beat_last = (beat_cnt_reg == last_idx);

    assign bus.buf_wr_data_begin = wr_valid && (beat_cnt_reg == '0);
    assign bus.buf_wr_data_last  = wr_valid && beat_last;

    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        if (data_pop) begin
            if (beat_last) beat_cnt_next = '0;
            else           beat_cnt_next = beat_cnt_reg + AVL_SIZE_WIDTH'(1);
        end
    end

    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
        if (ctl_reset) beat_cnt_reg <= '0;
        else           beat_cnt_reg <= beat_cnt_next;
    end
endmodule

// File: tb/tb_alt_mem_ddrx_itf_cmd_buffer.sv
// Directed bench for the command buffer: each task drives one scenario and checks
// the downstream ports against hand-computed values at the falling clock edge.
module tb_alt_mem_ddrx_itf_cmd_buffer;
    localparam int AW = 25;
    localparam int SW = 3;
    localparam int DW = 32;

    logic ctl_clk   = 1'b0;
    logic ctl_reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    alt_mem_ddrx_itf_cmd_buffer_if #(.AVL_ADDR_WIDTH(AW), .AVL_SIZE_WIDTH(SW), .AVL_DATA_WIDTH(DW)) bus ();

    alt_mem_ddrx_itf_cmd_buffer #(
        .AVL_ADDR_WIDTH(AW), .AVL_SIZE_WIDTH(SW), .AVL_DATA_WIDTH(DW),
        .CMD_FIFO_DEPTH(4), .DATA_FIFO_DEPTH(8)
    ) dut (
        .ctl_clk   (ctl_clk),
        .ctl_reset (ctl_reset),
        .bus       (bus)
    );

    always #5 ctl_clk = ~ctl_clk;

    task idle_inputs;
        bus.itf_cmd_valid       = 1'b0;
        bus.itf_cmd             = 1'b0;
        bus.itf_cmd_address     = '0;
        bus.itf_cmd_burstlen    = '0;
        bus.itf_wr_data_valid   = 1'b0;
        bus.itf_wr_data         = '0;
        bus.itf_wr_data_byte_en = '0;
        bus.buf_cmd_ready       = 1'b0;
        bus.buf_wr_data_ready   = 1'b0;
    endtask

    task test_reset;
        idle_inputs();
        ctl_reset = 1'b1;
        #1;
        total++; if (bus.buf_cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_cmd_valid got=%b exp=0", bus.buf_cmd_valid); end
        total++; if (bus.buf_wr_data_valid !== 1'b0) begin bad++; $display("FAIL rst_wr_valid got=%b exp=0", bus.buf_wr_data_valid); end
        total++; if (bus.buf_wr_data_begin !== 1'b0) begin bad++; $display("FAIL rst_begin got=%b exp=0", bus.buf_wr_data_begin); end
        total++; if (bus.buf_wr_data_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b exp=0", bus.buf_wr_data_last); end
        total++; if (bus.itf_cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.itf_cmd_ready); end
        total++; if (bus.itf_wr_data_ready !== 1'b1) begin bad++; $display("FAIL rst_wr_ready got=%b exp=1", bus.itf_wr_data_ready); end
        @(negedge ctl_clk);
        ctl_reset = 1'b0;
        $display("reset checked");
    endtask

    task test_single_burst;
        logic [DW-1:0] exp_data;
        logic [3:0]    exp_be;
        @(negedge ctl_clk);
        bus.buf_cmd_ready = 1'b1; bus.buf_wr_data_ready = 1'b1;
        bus.itf_cmd_valid = 1'b1; bus.itf_cmd = 1'b1;
        bus.itf_cmd_address = 25'h100; bus.itf_cmd_burstlen = 3'd4;
        bus.itf_wr_data_valid = 1'b1; bus.itf_wr_data = 32'h11; bus.itf_wr_data_byte_en = 4'h1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ctl_clk);
            if (i == 0) begin
                total++; if (bus.buf_cmd_valid !== 1'b1) begin bad++; $display("FAIL sb_cmd_valid got=%b exp=1", bus.buf_cmd_valid); end
                total++; if (bus.buf_cmd_write !== 1'b1) begin bad++; $display("FAIL sb_cmd_write got=%b exp=1", bus.buf_cmd_write); end
                total++; if (bus.buf_cmd_address !== 25'h100) begin bad++; $display("FAIL sb_cmd_addr got=%h exp=100", bus.buf_cmd_address); end
                total++; if (bus.buf_cmd_burstlen !== 3'd4) begin bad++; $display("FAIL sb_cmd_len got=%0d exp=4", bus.buf_cmd_burstlen); end
                bus.itf_cmd_valid = 1'b0;
            end
            if (i == 1) begin
                total++; if (bus.buf_cmd_valid !== 1'b0) begin bad++; $display("FAIL sb_cmd_drained got=%b exp=0", bus.buf_cmd_valid); end
            end
            exp_data = 32'(32'h11 * (i + 1));
            exp_be   = 4'(1 << i);
            $display("single burst beat %0d data=%h begin=%b last=%b", i, bus.buf_wr_data, bus.buf_wr_data_begin, bus.buf_wr_data_last);
            total++; if (bus.buf_wr_data_valid !== 1'b1) begin bad++; $display("FAIL sb_valid%0d got=%b exp=1", i, bus.buf_wr_data_valid); end
            total++; if (bus.buf_wr_data !== exp_data) begin bad++; $display("FAIL sb_data%0d got=%h exp=%h", i, bus.buf_wr_data, exp_data); end
            total++; if (bus.buf_wr_data_byte_en !== exp_be) begin bad++; $display("FAIL sb_be%0d got=%h exp=%h", i, bus.buf_wr_data_byte_en, exp_be); end
            total++; if (bus.buf_wr_data_begin !== (i == 0)) begin bad++; $display("FAIL sb_begin%0d got=%b exp=%b", i, bus.buf_wr_data_begin, (i == 0)); end
            total++; if (bus.buf_wr_data_last !== (i == 3)) begin bad++; $display("FAIL sb_last%0d got=%b exp=%b", i, bus.buf_wr_data_last, (i == 3)); end
            if (i < 3) begin
                bus.itf_wr_data = 32'(32'h11 * (i + 2));
                bus.itf_wr_data_byte_en = 4'(1 << (i + 1));
            end else begin
                bus.itf_wr_data_valid = 1'b0;
            end
        end
        @(negedge ctl_clk);
        total++; if (bus.buf_wr_data_valid !== 1'b0) begin bad++; $display("FAIL sb_end_valid got=%b exp=0", bus.buf_wr_data_valid); end
    endtask

    task test_len1_len2;
        bus.buf_wr_data_ready = 1'b0; bus.buf_cmd_ready = 1'b1;
        bus.itf_cmd_valid = 1'b1; bus.itf_cmd = 1'b1; bus.itf_cmd_address = 25'h10; bus.itf_cmd_burstlen = 3'd1;
        bus.itf_wr_data_valid = 1'b1; bus.itf_wr_data = 32'hA1; bus.itf_wr_data_byte_en = 4'hF;
        @(negedge ctl_clk);
        bus.itf_cmd_address = 25'h20; bus.itf_cmd_burstlen = 3'd2; bus.itf_wr_data = 32'hB2;
        @(negedge ctl_clk);
        bus.itf_cmd_valid = 1'b0; bus.itf_wr_data = 32'hC3;
        @(negedge ctl_clk);
        bus.itf_wr_data_valid = 1'b0;
        $display("len1/len2 beat 1 data=%h begin=%b last=%b", bus.buf_wr_data, bus.buf_wr_data_begin, bus.buf_wr_data_last);
        total++; if (bus.buf_wr_data !== 32'hA1) begin bad++; $display("FAIL l12_data1 got=%h exp=a1", bus.buf_wr_data); end
        total++; if ({bus.buf_wr_data_begin, bus.buf_wr_data_last} !== 2'b11) begin bad++; $display("FAIL l12_bl1 got=%b%b exp=11", bus.buf_wr_data_begin, bus.buf_wr_data_last); end
        bus.buf_wr_data_ready = 1'b1;
        @(negedge ctl_clk);
        $display("len1/len2 beat 2 data=%h begin=%b last=%b", bus.buf_wr_data, bus.buf_wr_data_begin, bus.buf_wr_data_last);
        total++; if (bus.buf_wr_data !== 32'hB2) begin bad++; $display("FAIL l12_data2 got=%h exp=b2", bus.buf_wr_data); end
        total++; if ({bus.buf_wr_data_begin, bus.buf_wr_data_last} !== 2'b10) begin bad++; $display("FAIL l12_bl2 got=%b%b exp=10", bus.buf_wr_data_begin, bus.buf_wr_data_last); end
        @(negedge ctl_clk);
        $display("len1/len2 beat 3 data=%h begin=%b last=%b", bus.buf_wr_data, bus.buf_wr_data_begin, bus.buf_wr_data_last);
        total++; if (bus.buf_wr_data !== 32'hC3) begin bad++; $display("FAIL l12_data3 got=%h exp=c3", bus.buf_wr_data); end
        total++; if ({bus.buf_wr_data_begin, bus.buf_wr_data_last} !== 2'b01) begin bad++; $display("FAIL l12_bl3 got=%b%b exp=01", bus.buf_wr_data_begin, bus.buf_wr_data_last); end
        @(negedge ctl_clk);
        total++; if (bus.buf_wr_data_valid !== 1'b0) begin bad++; $display("FAIL l12_end_valid got=%b exp=0", bus.buf_wr_data_valid); end
    endtask

    task test_cmd_full;
        bus.buf_cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge ctl_clk);
            bus.itf_cmd_valid = 1'b1; bus.itf_cmd = 1'b0;
            bus.itf_cmd_address = 25'(i + 1); bus.itf_cmd_burstlen = 3'd3;
        end
        @(negedge ctl_clk);
        total++; if (bus.itf_cmd_ready !== 1'b0) begin bad++; $display("FAIL cf_full_ready got=%b exp=0", bus.itf_cmd_ready); end
        total++; if (bus.buf_cmd_address !== 25'd1) begin bad++; $display("FAIL cf_head1 got=%0d exp=1", bus.buf_cmd_address); end
        bus.itf_cmd_address = 25'd5; bus.buf_cmd_ready = 1'b1;
        @(negedge ctl_clk);
        total++; if (bus.itf_cmd_ready !== 1'b1) begin bad++; $display("FAIL cf_freed_ready got=%b exp=1", bus.itf_cmd_ready); end
        bus.buf_cmd_ready = 1'b0;
        @(negedge ctl_clk);
        total++; if (bus.itf_cmd_ready !== 1'b0) begin bad++; $display("FAIL cf_refull_ready got=%b exp=0", bus.itf_cmd_ready); end
        bus.itf_cmd_valid = 1'b0; bus.buf_cmd_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            $display("cmd full drain %0d addr=%0d write=%b", j, bus.buf_cmd_address, bus.buf_cmd_write);
            total++; if (bus.buf_cmd_valid !== 1'b1) begin bad++; $display("FAIL cf_valid%0d got=%b exp=1", j, bus.buf_cmd_valid); end
            total++; if (bus.buf_cmd_address !== 25'(j + 2)) begin bad++; $display("FAIL cf_order%0d got=%0d exp=%0d", j, bus.buf_cmd_address, j + 2); end
            total++; if (bus.buf_cmd_write !== 1'b0) begin bad++; $display("FAIL cf_write%0d got=%b exp=0", j, bus.buf_cmd_write); end
            @(negedge ctl_clk);
        end
        total++; if (bus.buf_cmd_valid !== 1'b0) begin bad++; $display("FAIL cf_end_valid got=%b exp=0", bus.buf_cmd_valid); end
    endtask

    task test_data_no_cmd;
        bus.buf_cmd_ready = 1'b1; bus.buf_wr_data_ready = 1'b1;
        bus.itf_wr_data_valid = 1'b1; bus.itf_wr_data = 32'h5A5A0000; bus.itf_wr_data_byte_en = 4'h3;
        @(negedge ctl_clk);
        bus.itf_wr_data = 32'h5A5A0001; bus.itf_wr_data_byte_en = 4'hC;
        @(negedge ctl_clk);
        bus.itf_wr_data_valid = 1'b0;
        total++; if (bus.buf_wr_data_valid !== 1'b0) begin bad++; $display("FAIL nc_wait1 got=%b exp=0", bus.buf_wr_data_valid); end
        @(negedge ctl_clk);
        total++; if (bus.buf_wr_data_valid !== 1'b0) begin bad++; $display("FAIL nc_wait2 got=%b exp=0", bus.buf_wr_data_valid); end
        bus.itf_cmd_valid = 1'b1; bus.itf_cmd = 1'b1; bus.itf_cmd_address = 25'h300; bus.itf_cmd_burstlen = 3'd2;
        @(negedge ctl_clk);
        bus.itf_cmd_valid = 1'b0;
        $display("no-cmd beat 0 data=%h begin=%b last=%b", bus.buf_wr_data, bus.buf_wr_data_begin, bus.buf_wr_data_last);
        total++; if (bus.buf_wr_data_valid !== 1'b1) begin bad++; $display("FAIL nc_valid got=%b exp=1", bus.buf_wr_data_valid); end
        total++; if (bus.buf_wr_data !== 32'h5A5A0000) begin bad++; $display("FAIL nc_data0 got=%h exp=5a5a0000", bus.buf_wr_data); end
        total++; if ({bus.buf_wr_data_begin, bus.buf_wr_data_last} !== 2'b10) begin bad++; $display("FAIL nc_bl0 got=%b%b exp=10", bus.buf_wr_data_begin, bus.buf_wr_data_last); end
        @(negedge ctl_clk);
        $display("no-cmd beat 1 data=%h begin=%b last=%b", bus.buf_wr_data, bus.buf_wr_data_begin, bus.buf_wr_data_last);
        total++; if (bus.buf_wr_data !== 32'h5A5A0001) begin bad++; $display("FAIL nc_data1 got=%h exp=5a5a0001", bus.buf_wr_data); end
        total++; if (bus.buf_wr_data_byte_en !== 4'hC) begin bad++; $display("FAIL nc_be1 got=%h exp=c", bus.buf_wr_data_byte_en); end
        total++; if ({bus.buf_wr_data_begin, bus.buf_wr_data_last} !== 2'b01) begin bad++; $display("FAIL nc_bl1 got=%b%b exp=01", bus.buf_wr_data_begin, bus.buf_wr_data_last); end
        @(negedge ctl_clk);
        total++; if (bus.buf_wr_data_valid !== 1'b0) begin bad++; $display("FAIL nc_end_valid got=%b exp=0", bus.buf_wr_data_valid); end
    endtask

    task test_data_full;
        bus.buf_wr_data_ready = 1'b0; bus.buf_cmd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(negedge ctl_clk);
                $display("data full read cmd %0d addr=%h", i - 1, bus.buf_cmd_address);
                total++; if (bus.buf_cmd_valid !== 1'b1 || bus.buf_cmd_write !== 1'b0) begin bad++; $display("FAIL df_cmd%0d got=%b%b exp=10", i - 1, bus.buf_cmd_valid, bus.buf_cmd_write); end
                total++; if (bus.buf_cmd_address !== 25'(32'h200 + i - 1)) begin bad++; $display("FAIL df_addr%0d got=%h exp=%h", i - 1, bus.buf_cmd_address, 32'h200 + i - 1); end
                total++; if (bus.itf_wr_data_ready !== 1'b1) begin bad++; $display("FAIL df_ready%0d got=%b exp=1", i, bus.itf_wr_data_ready); end
            end
            bus.itf_wr_data_valid = 1'b1; bus.itf_wr_data = 32'(32'hD0 + i); bus.itf_wr_data_byte_en = 4'hF;
            bus.itf_cmd_valid = 1'b1; bus.itf_cmd = 1'b0; bus.itf_cmd_address = 25'(32'h200 + i); bus.itf_cmd_burstlen = 3'd2;
        end
        @(negedge ctl_clk);
        bus.itf_cmd_valid = 1'b0;
        total++; if (bus.buf_cmd_address !== 25'h207) begin bad++; $display("FAIL df_addr7 got=%h exp=207", bus.buf_cmd_address); end
        total++; if (bus.itf_wr_data_ready !== 1'b0) begin bad++; $display("FAIL df_full_ready got=%b exp=0", bus.itf_wr_data_ready); end
        total++; if (bus.buf_wr_data_valid !== 1'b0) begin bad++; $display("FAIL df_no_len_valid got=%b exp=0", bus.buf_wr_data_valid); end
        @(negedge ctl_clk);
        bus.itf_wr_data_valid = 1'b0;
        total++; if (bus.itf_wr_data_ready !== 1'b0) begin bad++; $display("FAIL df_hold_ready got=%b exp=0", bus.itf_wr_data_ready); end
    endtask

    task test_reset_mid_burst;
        ctl_reset = 1'b1;
        @(negedge ctl_clk);
        ctl_reset = 1'b0;
        bus.buf_wr_data_ready = 1'b0; bus.buf_cmd_ready = 1'b1;
        bus.itf_cmd_valid = 1'b1; bus.itf_cmd = 1'b1; bus.itf_cmd_address = 25'h400; bus.itf_cmd_burstlen = 3'd4;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge ctl_clk);
            if (i == 1) bus.itf_cmd_valid = 1'b0;
            bus.itf_wr_data_valid = 1'b1; bus.itf_wr_data = 32'(32'hE0 + i); bus.itf_wr_data_byte_en = 4'hF;
        end
        @(negedge ctl_clk);
        bus.itf_wr_data_valid = 1'b0; bus.buf_wr_data_ready = 1'b1;
        @(negedge ctl_clk);
        @(negedge ctl_clk);
        total++; if (bus.buf_wr_data !== 32'hE2 || bus.buf_wr_data_begin !== 1'b0) begin bad++; $display("FAIL rm_pre data=%h begin=%b exp=e2/0", bus.buf_wr_data, bus.buf_wr_data_begin); end
        bus.buf_wr_data_ready = 1'b0;
        ctl_reset = 1'b1;
        #1;
        total++; if (bus.buf_wr_data_valid !== 1'b0) begin bad++; $display("FAIL rm_wr_valid got=%b exp=0", bus.buf_wr_data_valid); end
        total++; if (bus.buf_cmd_valid !== 1'b0) begin bad++; $display("FAIL rm_cmd_valid got=%b exp=0", bus.buf_cmd_valid); end
        total++; if ({bus.buf_wr_data_begin, bus.buf_wr_data_last} !== 2'b00) begin bad++; $display("FAIL rm_bl got=%b%b exp=00", bus.buf_wr_data_begin, bus.buf_wr_data_last); end
        total++; if ({bus.itf_cmd_ready, bus.itf_wr_data_ready} !== 2'b11) begin bad++; $display("FAIL rm_ready got=%b%b exp=11", bus.itf_cmd_ready, bus.itf_wr_data_ready); end
        @(negedge ctl_clk);
        ctl_reset = 1'b0; bus.buf_wr_data_ready = 1'b1;
        @(negedge ctl_clk);
        bus.itf_cmd_valid = 1'b1; bus.itf_cmd = 1'b1; bus.itf_cmd_address = 25'h500; bus.itf_cmd_burstlen = 3'd2;
        bus.itf_wr_data_valid = 1'b1; bus.itf_wr_data = 32'hAA;
        @(negedge ctl_clk);
        bus.itf_cmd_valid = 1'b0; bus.itf_wr_data = 32'hBB;
        $display("post-reset beat 0 data=%h begin=%b last=%b", bus.buf_wr_data, bus.buf_wr_data_begin, bus.buf_wr_data_last);
        total++; if (bus.buf_wr_data_valid !== 1'b1 || bus.buf_wr_data !== 32'hAA) begin bad++; $display("FAIL rm_data0 valid=%b data=%h exp=1/aa", bus.buf_wr_data_valid, bus.buf_wr_data); end
        total++; if ({bus.buf_wr_data_begin, bus.buf_wr_data_last} !== 2'b10) begin bad++; $display("FAIL rm_bl0 got=%b%b exp=10", bus.buf_wr_data_begin, bus.buf_wr_data_last); end
        @(negedge ctl_clk);
        bus.itf_wr_data_valid = 1'b0;
        $display("post-reset beat 1 data=%h begin=%b last=%b", bus.buf_wr_data, bus.buf_wr_data_begin, bus.buf_wr_data_last);
        total++; if (bus.buf_wr_data !== 32'hBB) begin bad++; $display("FAIL rm_data1 got=%h exp=bb", bus.buf_wr_data); end
        total++; if ({bus.buf_wr_data_begin, bus.buf_wr_data_last} !== 2'b01) begin bad++; $display("FAIL rm_bl1 got=%b%b exp=01", bus.buf_wr_data_begin, bus.buf_wr_data_last); end
        @(negedge ctl_clk);
        total++; if (bus.buf_wr_data_valid !== 1'b0) begin bad++; $display("FAIL rm_end_valid got=%b exp=0", bus.buf_wr_data_valid); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_len1_len2();
        test_cmd_full();
        test_data_no_cmd();
        test_data_full();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
